// File: rtl/receiver_calc.sv
// Receive-side line assembler: edits a text line from the UART byte stream, then
// converts the completed line to an unsigned decimal operand, one character per cycle.
module receiver_calc #(
  parameter int DATASIZE = 128,
  parameter int VALUE_W  = 32
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                uart_rx_valid,
  input  logic [7:0]          uart_rx_data,
  input  logic                uart_rx_break,
  output logic [DATASIZE-1:0] line,
  output logic [7:0]          line_len,
  output logic                line_valid,
  output logic                is_num,
  output logic [VALUE_W-1:0]  value,
  output logic                num_ovf,
  output logic                line_err,
  output logic                busy
);
  localparam int MAXLEN = DATASIZE / 8;
  localparam int IDX_W  = $clog2(MAXLEN);

  typedef enum logic [1:0] {COLLECT, DRAIN, CONVERT} state_t;

  state_t              state;
  logic [DATASIZE-1:0] wbuf, sbuf, wbuf_edit;
  logic [7:0]          wlen, slen, wlen_edit;
  logic [IDX_W-1:0]    sidx;
  logic [VALUE_W-1:0]  acc, step_acc;
  logic                num_f, ovf_f, step_num, step_ovf;
  logic                ovf_pend, brk_q;
  logic                is_cr, is_bs, is_print, print_full;
  logic [7:0]          cur_ch;
  logic                cur_digit;
  logic [VALUE_W:0]    mac;

  // acc*10 + d with saturation to all-ones; MSB of the result flags saturation.
  function automatic logic [VALUE_W:0] sat_mac10(input logic [VALUE_W-1:0] a,
                                                 input logic [3:0]         d);
    logic [VALUE_W+3:0] w;
    w = {4'b0000, a} * (VALUE_W+4)'(10) + {{VALUE_W{1'b0}}, d};
    if (w[VALUE_W+3:VALUE_W] != 4'b0000)
      return {1'b1, {VALUE_W{1'b1}}};
    return {1'b0, w[VALUE_W-1:0]};
  endfunction

  always_comb begin
    is_cr      = uart_rx_valid && (uart_rx_data == 8'h0D);
    is_bs      = uart_rx_valid && (uart_rx_data == 8'h08 || uart_rx_data == 8'h7F);
    is_print   = uart_rx_valid && (uart_rx_data >= 8'h20) && (uart_rx_data <= 8'h7E);
    print_full = is_print && (wlen >= 8'(MAXLEN));
    wbuf_edit  = wbuf;
    wlen_edit  = wlen;
    if (is_bs && wlen != 8'd0) begin
      wbuf_edit = {8'h00, wbuf[DATASIZE-1:8]};
      wlen_edit = wlen - 8'd1;
    end else if (is_print && !print_full) begin
      wbuf_edit = {wbuf[DATASIZE-9:0], uart_rx_data};
      wlen_edit = wlen + 8'd1;
    end
  end

  always_comb begin
    cur_ch    = sbuf[{sidx, 3'b000} +: 8];
    cur_digit = (cur_ch >= 8'h30) && (cur_ch <= 8'h39);
    mac       = sat_mac10(acc, cur_digit ? cur_ch[3:0] : 4'd0);
    step_acc  = mac[VALUE_W-1:0];
    step_ovf  = ovf_f | mac[VALUE_W];
    step_num  = num_f & cur_digit;
  end

  assign busy = (state == CONVERT);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state      <= COLLECT;
      wbuf       <= '0;
      wlen       <= '0;
      sbuf       <= '0;
      slen       <= '0;
      sidx       <= '0;
      acc        <= '0;
      num_f      <= 1'b0;
      ovf_f      <= 1'b0;
      ovf_pend   <= 1'b0;
      brk_q      <= 1'b0;
      line       <= '0;
      line_len   <= '0;
      line_valid <= 1'b0;
      is_num     <= 1'b0;
      value      <= '0;
      num_ovf    <= 1'b0;
      line_err   <= 1'b0;
    end else begin
      line_valid <= 1'b0;
      line_err   <= 1'b0;
      brk_q      <= uart_rx_break;
      if (uart_rx_break) begin
        state    <= COLLECT;
        wbuf     <= '0;
        wlen     <= '0;
        ovf_pend <= 1'b0;
        line_err <= !brk_q;
      end else begin
        unique case (state)
          COLLECT: begin
            if (is_cr) begin
              wbuf <= '0;
              wlen <= '0;
              if (wlen == 8'd0) begin
                line       <= '0;
                line_len   <= '0;
                is_num     <= 1'b0;
                value      <= '0;
                num_ovf    <= 1'b0;
                line_valid <= 1'b1;
              end else begin
                sbuf  <= wbuf;
                slen  <= wlen;
                sidx  <= IDX_W'(wlen - 8'd1);
                acc   <= '0;
                num_f <= 1'b1;
                ovf_f <= 1'b0;
                state <= CONVERT;
              end
            end else if (print_full) begin
              state <= DRAIN;
            end else begin
              wbuf <= wbuf_edit;
              wlen <= wlen_edit;
            end
          end
          DRAIN: begin
            if (is_cr) begin
              line_err <= 1'b1;
              wbuf     <= '0;
              wlen     <= '0;
              state    <= COLLECT;
            end
          end
          CONVERT: begin
            acc   <= step_acc;
            num_f <= step_num;
            ovf_f <= step_ovf;
            sidx  <= sidx - 1'b1;
            // The next line keeps collecting; an overflowing one is remembered
            // so it can be drained once this conversion has finished.
            if (is_cr) begin
              line_err <= 1'b1;
              wbuf     <= '0;
              wlen     <= '0;
            end else if (!ovf_pend) begin
              wbuf <= wbuf_edit;
              wlen <= wlen_edit;
            end
            if (sidx == '0) begin
              line       <= sbuf;
              line_len   <= slen;
              is_num     <= step_num;
              value      <= step_num ? step_acc : '0;
              num_ovf    <= step_num & step_ovf;
              line_valid <= 1'b1;
              ovf_pend   <= 1'b0;
              state      <= (!is_cr && (ovf_pend || print_full)) ? DRAIN : COLLECT;
            end else if (is_cr) begin
              ovf_pend <= 1'b0;
            end else if (print_full) begin
              ovf_pend <= 1'b1;
            end
          end
          default: state <= COLLECT;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_receiver_calc.sv
// Directed bench for receiver_calc: line editing, conversion, timing, errors and reset.
module tb_receiver_calc;
  localparam int DATASIZE = 128;
  localparam int VALUE_W  = 32;

  logic                clk = 1'b0;
  logic                resetn = 1'b0;
  logic                uart_rx_valid = 1'b0;
  logic [7:0]          uart_rx_data = 8'h00;
  logic                uart_rx_break = 1'b0;
  logic [DATASIZE-1:0] line;
  logic [7:0]          line_len;
  logic                line_valid;
  logic                is_num;
  logic [VALUE_W-1:0]  value;
  logic                num_ovf;
  logic                line_err;
  logic                busy;

  int checks = 0;
  int errors = 0;
  int lv_cnt = 0;
  int le_cnt = 0;

  always #5 clk = ~clk;

  receiver_calc #(.DATASIZE(DATASIZE), .VALUE_W(VALUE_W)) dut (
    .clk(clk), .resetn(resetn), .uart_rx_valid(uart_rx_valid),
    .uart_rx_data(uart_rx_data), .uart_rx_break(uart_rx_break),
    .line(line), .line_len(line_len), .line_valid(line_valid), .is_num(is_num),
    .value(value), .num_ovf(num_ovf), .line_err(line_err), .busy(busy)
  );

  always @(negedge clk) begin
    if (line_valid === 1'b1) lv_cnt++;
    if (line_err === 1'b1) le_cnt++;
  end

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk); uart_rx_valid = 1'b1; uart_rx_data = b;
    @(negedge clk); uart_rx_valid = 1'b0; uart_rx_data = 8'h00;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i]);
  endtask

  task automatic wait_valid(input int max, output bit got);
    got = 1'b0;
    for (int i = 0; i < max; i++) begin
      if (line_valid === 1'b1) begin got = 1'b1; break; end
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    resetn = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (line !== '0) begin errors++; $display("FAIL reset_line got %h want 0", line); end
    checks++; if (line_len !== 8'd0) begin errors++; $display("FAIL reset_len got %0d want 0", line_len); end
    checks++; if (line_valid !== 1'b0 || line_err !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL reset_pulses got v=%b e=%b b=%b want 0", line_valid, line_err, busy); end
    checks++; if (is_num !== 1'b0 || num_ovf !== 1'b0 || value !== '0) begin errors++; $display("FAIL reset_num got n=%b o=%b v=%h want 0", is_num, num_ovf, value); end
    resetn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic;
    bit got;
    send_str("123");
    send_byte(8'h0D);
    checks++; if (busy !== 1'b1 || line_valid !== 1'b0) begin errors++; $display("FAIL basic_t1 got busy=%b valid=%b want 1 0", busy, line_valid); end
    @(negedge clk); @(negedge clk);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_t3_busy got %b want 1", busy); end
    @(negedge clk);
    checks++; if (line_valid !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL basic_t4 got valid=%b busy=%b want 1 0", line_valid, busy); end
    checks++; if (line_len !== 8'd3) begin errors++; $display("FAIL basic_len got %0d want 3", line_len); end
    checks++; if (line !== 128'h313233) begin errors++; $display("FAIL basic_line got %h want 313233", line); end
    checks++; if (is_num !== 1'b1 || value !== 32'd123 || num_ovf !== 1'b0) begin errors++; $display("FAIL basic_value got n=%b v=%0d o=%b want 1 123 0", is_num, value, num_ovf); end
    @(negedge clk);
    checks++; if (line_valid !== 1'b0) begin errors++; $display("FAIL basic_pulse_width got %b want 0", line_valid); end
    wait_valid(1, got);
  endtask

  task automatic test_edit;
    bit got;
    send_str("12X");
    send_byte(8'h08);
    send_str("4");
    send_byte(8'h0D);
    wait_valid(30, got);
    checks++; if (!got) begin errors++; $display("FAIL edit_timeout got none want line_valid"); end
    checks++; if (line !== 128'h313234 || line_len !== 8'd3) begin errors++; $display("FAIL edit_line got %h len %0d want 313234 len 3", line, line_len); end
    checks++; if (value !== 32'd124 || is_num !== 1'b1) begin errors++; $display("FAIL edit_value got %0d n=%b want 124 1", value, is_num); end
  endtask

  task automatic test_empty;
    send_byte(8'h0D);
    checks++; if (line_valid !== 1'b1) begin errors++; $display("FAIL empty_valid got %b want 1", line_valid); end
    checks++; if (line_len !== 8'd0 || is_num !== 1'b0 || value !== '0 || line !== '0) begin errors++; $display("FAIL empty_out got len=%0d n=%b v=%0d line=%h want 0 0 0 0", line_len, is_num, value, line); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL empty_busy got %b want 0", busy); end
    @(negedge clk);
  endtask

  task automatic test_nonnum;
    bit got;
    send_str("A5");
    send_byte(8'h0D);
    wait_valid(30, got);
    checks++; if (!got) begin errors++; $display("FAIL nonnum_timeout got none want line_valid"); end
    checks++; if (line !== 128'h4135 || line_len !== 8'd2) begin errors++; $display("FAIL nonnum_line got %h len %0d want 4135 len 2", line, line_len); end
    checks++; if (is_num !== 1'b0 || value !== '0 || num_ovf !== 1'b0) begin errors++; $display("FAIL nonnum_value got n=%b v=%0d o=%b want 0 0 0", is_num, value, num_ovf); end
  endtask

  task automatic test_ovf;
    bit got;
    send_str("4294967296");
    send_byte(8'h0D);
    wait_valid(30, got);
    checks++; if (!got) begin errors++; $display("FAIL ovf_timeout got none want line_valid"); end
    checks++; if (value !== 32'hFFFFFFFF || num_ovf !== 1'b1 || is_num !== 1'b1) begin errors++; $display("FAIL ovf_sat got v=%h o=%b n=%b want ffffffff 1 1", value, num_ovf, is_num); end
    checks++; if (line_len !== 8'd10) begin errors++; $display("FAIL ovf_len got %0d want 10", line_len); end
    send_str("4294967295");
    send_byte(8'h0D);
    wait_valid(30, got);
    checks++; if (!got) begin errors++; $display("FAIL max_timeout got none want line_valid"); end
    checks++; if (value !== 32'hFFFFFFFF || num_ovf !== 1'b0) begin errors++; $display("FAIL max_exact got v=%h o=%b want ffffffff 0", value, num_ovf); end
  endtask

  task automatic test_line_overflow;
    bit got;
    int lv0, le0;
    @(negedge clk);
    lv0 = lv_cnt; le0 = le_cnt;
    send_str("abcdefghijklmnopq");
    send_byte(8'h0D);
    checks++; if (line_err !== 1'b1) begin errors++; $display("FAIL lovf_err got %b want 1", line_err); end
    repeat (20) @(negedge clk);
    checks++; if (lv_cnt !== lv0) begin errors++; $display("FAIL lovf_novalid got %0d want %0d", lv_cnt, lv0); end
    checks++; if (le_cnt !== le0 + 1) begin errors++; $display("FAIL lovf_errcnt got %0d want %0d", le_cnt, le0 + 1); end
    checks++; if (value !== 32'hFFFFFFFF || line_len !== 8'd10 || num_ovf !== 1'b0) begin errors++; $display("FAIL lovf_held got v=%h len=%0d o=%b want ffffffff 10 0", value, line_len, num_ovf); end
    send_str("7");
    send_byte(8'h0D);
    wait_valid(30, got);
    checks++; if (!got || value !== 32'd7 || line_len !== 8'd1) begin errors++; $display("FAIL lovf_next got g=%b v=%0d len=%0d want 1 7 1", got, value, line_len); end
  endtask

  task automatic test_ignored;
    bit got;
    send_byte(8'h08);
    send_byte(8'h7F);
    send_str("9");
    send_byte(8'h0A);
    send_byte(8'h01);
    send_str("8");
    send_byte(8'h0D);
    wait_valid(30, got);
    checks++; if (!got) begin errors++; $display("FAIL ign_timeout got none want line_valid"); end
    checks++; if (value !== 32'd98 || line_len !== 8'd2 || line !== 128'h3938) begin errors++; $display("FAIL ign_value got v=%0d len=%0d line=%h want 98 2 3938", value, line_len, line); end
  endtask

  task automatic test_back_to_back;
    bit got;
    send_str("12");
    send_byte(8'h0D);
    send_str("5");
    wait_valid(30, got);
    checks++; if (!got || value !== 32'd12) begin errors++; $display("FAIL b2b_first got g=%b v=%0d want 1 12", got, value); end
    send_byte(8'h0D);
    wait_valid(30, got);
    checks++; if (!got || value !== 32'd5 || line_len !== 8'd1) begin errors++; $display("FAIL b2b_append got g=%b v=%0d len=%0d want 1 5 1", got, value, line_len); end
    send_str("34567");
    send_byte(8'h0D);
    send_str("8");
    send_byte(8'h0D);
    checks++; if (line_err !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL b2b_crconv got err=%b busy=%b want 1 1", line_err, busy); end
    wait_valid(30, got);
    checks++; if (!got || value !== 32'd34567) begin errors++; $display("FAIL b2b_conv got g=%b v=%0d want 1 34567", got, value); end
    send_str("6");
    send_byte(8'h0D);
    wait_valid(30, got);
    checks++; if (!got || value !== 32'd6 || line_len !== 8'd1) begin errors++; $display("FAIL b2b_dropped got g=%b v=%0d len=%0d want 1 6 1", got, value, line_len); end
  endtask

  task automatic test_break;
    bit got;
    int le0;
    send_str("55");
    le0 = le_cnt;
    @(negedge clk); uart_rx_break = 1'b1;
    @(negedge clk);
    checks++; if (line_err !== 1'b1) begin errors++; $display("FAIL brk_err got %b want 1", line_err); end
    @(negedge clk);
    checks++; if (line_err !== 1'b0) begin errors++; $display("FAIL brk_once got %b want 0", line_err); end
    @(negedge clk); uart_rx_break = 1'b0;
    @(negedge clk); @(negedge clk);
    checks++; if (le_cnt !== le0 + 1) begin errors++; $display("FAIL brk_count got %0d want %0d", le_cnt, le0 + 1); end
    send_str("3");
    send_byte(8'h0D);
    wait_valid(30, got);
    checks++; if (!got || value !== 32'd3 || line !== 128'h33) begin errors++; $display("FAIL brk_next got g=%b v=%0d line=%h want 1 3 33", got, value, line); end
  endtask

  task automatic test_reset_mid;
    int lv0;
    send_str("99");
    send_byte(8'h0D);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rmid_busy got %b want 1", busy); end
    resetn = 1'b0;
    @(negedge clk);
    lv0 = lv_cnt;
    checks++; if (value !== '0 || line !== '0 || line_len !== 8'd0 || is_num !== 1'b0 || busy !== 1'b0 || line_valid !== 1'b0) begin errors++; $display("FAIL rmid_zero got v=%0d line=%h len=%0d n=%b b=%b lv=%b want all 0", value, line, line_len, is_num, busy, line_valid); end
    resetn = 1'b1;
    repeat (6) @(negedge clk);
    checks++; if (lv_cnt !== lv0 || value !== '0) begin errors++; $display("FAIL rmid_novalid got cnt=%0d v=%0d want %0d 0", lv_cnt, value, lv0); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_edit();
    test_empty();
    test_nonnum();
    test_ovf();
    test_line_overflow();
    test_ignored();
    test_back_to_back();
    test_break();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
